sumator_serial_cal: RTL and testbench
=====================================

SUMATOR_SERIAL_CAL -- requirements
Module: sumator_serial_cal

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES (16 at default).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operands A, B, cin present.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 A  input  W  first operand.
REQ-007 B  input  W  second operand.
REQ-008 cin  input  1  carry into bit 0.
REQ-009 out_valid  output  1  sum, cout and ovf valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 sum  output  W  result.
REQ-012 cout  output  1  carry out of bit W-1.
REQ-013 ovf  output  1  two's-complement overflow.

Function
REQ-014 Datapath shall use exactly one combinational 4-bit carry-lookahead slice (sum = p^c, group P = &p, group G = lookahead generate), reused once per nibble, LSB nibble first.
REQ-015 FSM states: IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 IDLE: on in_valid & in_ready, latch A, B into operand registers, load carry register with cin, clear nibble index, go to RUN.
REQ-017 RUN: each cycle, feed slice with nibble[idx] of latched A, B and carry register; write slice sum into sum[4*idx+3:4*idx]; carry register <= G | (P & carry); idx <= idx+1.
REQ-018 RUN -> DONE on the edge processing idx = NIBBLES-1; cout <= final carry at that edge.
REQ-019 Latency: handshake at edge k, out_valid high after edge k+NIBBLES (k+4 at default).
REQ-020 DONE: sum, cout, ovf held stable while out_ready = 0; on out_ready = 1, go to IDLE at that edge.
REQ-021 ovf = (A[W-1] == Beff[W-1]) & (sum[W-1] != A[W-1]), with latched operands; Beff = B unless modified per REQ-028.
REQ-022 in_valid ignored outside IDLE; inputs A, B, cin may change freely after handshake without affecting the result.
REQ-023 Minimum issue interval NIBBLES+2 cycles (handshake, NIBBLES RUN cycles, DONE cycle with out_ready = 1, IDLE).
REQ-024 Nibble index width ceil(log2(NIBBLES)), minimum 1 bit; no wrap beyond NIBBLES-1.
REQ-025 Arithmetic modulo 2^W; cout carries the W-th bit.

Reset
REQ-026 rst = 1 at a rising edge forces IDLE, idx = 0, carry register = 0, sum = 0, cout = 0, ovf = 0, in_ready = 1, out_valid = 0, in any state including mid-RUN and DONE; no result emitted for an aborted operation.
REQ-027 rst has priority over in_valid and out_ready in the same cycle.

Configuration
REQ-028 Macro SUMATOR_SERIAL_SUB_EN: when defined, add input port sub (1 bit, latched at handshake); sub = 1 latches Beff = ~B and carry register = 1 (cin ignored), giving A - B; sub = 0 behaves as without macro.
REQ-029 Without SUMATOR_SERIAL_SUB_EN: no sub port; Beff = B; carry register loaded from cin.

Verification
REQ-030 A=16'h0001, B=16'h0002, cin=0, out_ready=1 -> out_valid 4 cycles after handshake, sum=16'h0003, cout=0, ovf=0.
REQ-031 A=16'hFFFF, B=16'h0000, cin=1 -> sum=16'h0000, cout=1, ovf=0 (ripple across all 4 nibbles via P).
REQ-032 A=16'h7FFF, B=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1.
REQ-033 Result stall: out_ready=0 for 5 cycles after out_valid -> sum held, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-034 rst asserted on 2nd RUN cycle -> next cycle IDLE, out_valid=0, sum=0; following op A=16'h1234, B=16'h4321 -> sum=16'h5555.
REQ-035 With SUMATOR_SERIAL_SUB_EN: sub=1, A=16'h0005, B=16'h0007 -> sum=16'hFFFE, cout=0, ovf=0.

Source files
------------

// File: rtl/sumator_serial_cal.sv
// sumator_serial_cal: nibble-serial CLA adder; define SUMATOR_SERIAL_SUB_EN to add the sub port for A - B
module sumator_serial_cal_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c,
    output logic [3:0] s,
    output logic       gp,
    output logic       gg
);
    logic [3:0] p, g, cc;
    assign p = a ^ b;
    assign g = a & b;
    assign cc[0] = c;
    assign cc[1] = g[0] | (p[0] & c);
    assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign gp = &p;
    assign s = p ^ cc;
endmodule

module sumator_serial_cal #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 cin,
`ifdef SUMATOR_SERIAL_SUB_EN
    input  logic                 sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);
    localparam int W = 4 * NIBBLES;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [W-1:0] a_r, b_r;
    logic [IW-1:0] idx;
    logic carry, sl_p, sl_g, carry_n;
    logic [3:0] sl_s;
    sumator_serial_cal_cla4 u_cla (
        .a (a_r[4*idx +: 4]),
        .b (b_r[4*idx +: 4]),
        .c (carry),
        .s (sl_s),
        .gp(sl_p),
        .gg(sl_g)
    );
    assign carry_n = sl_g | (sl_p & carry);
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    a_r      <= A;
`ifdef SUMATOR_SERIAL_SUB_EN
                    b_r      <= sub ? ~B : B;
                    carry    <= sub | cin;
`else
                    b_r      <= B;
                    carry    <= cin;
`endif
                    idx      <= '0;
                    in_ready <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    sum[4*idx +: 4] <= sl_s;
                    carry           <= carry_n;
                    idx             <= idx + IW'(1);
                    if (idx == LAST) begin
                        idx       <= '0;
                        cout      <= carry_n;
                        ovf       <= (a_r[W-1] == b_r[W-1]) & (sl_s[3] != a_r[W-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sumator_serial_cal.sv
// tb_sumator_serial_cal: scoreboard bench comparing the serial adder against plain-arithmetic addition
module tb_sumator_serial_cal;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;
    logic clk = 0, rst = 1, in_valid = 0, cin = 0, out_ready = 1, sub_v = 0;
    logic [W-1:0] A = '0, B = '0;
    logic in_ready, out_valid, cout, ovf;
    logic [W-1:0] sum;
    logic rand_ready = 0, hold_ready = 1;
    logic [W+1:0] q[$];
    logic [W+1:0] mon_e, dummy;
    int checks = 0, errors = 0;

    sumator_serial_cal #(.NIBBLES(NIBBLES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .cin(cin),
`ifdef SUMATOR_SERIAL_SUB_EN
        .sub(sub_v),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : hold_ready;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: full-width addition, overflow from operand/result sign bits
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        logic [W-1:0] be;
        logic [W:0] t;
        logic ci;
`ifdef SUMATOR_SERIAL_SUB_EN
        be = s ? ~b : b;
        ci = s ? 1'b1 : c;
`else
        be = b;
        ci = c;
`endif
        t = {1'b0, a} + {1'b0, be} + (W + 1)'(ci);
        return {t[W-1:0], t[W], (a[W-1] == be[W-1]) && (t[W-1] != a[W-1])};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result got %h expected none", {sum, cout, ovf});
            end else begin
                mon_e = q.pop_front();
                check("result", {sum, cout, ovf}, mon_e);
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout got in_ready=0 expected 1");
        end
        A = a; B = b; cin = c; sub_v = s; in_valid = 1;
        q.push_back(model(a, b, c, s));
        @(posedge clk);
        #1;
        in_valid = 0; A = W'($urandom); B = W'($urandom); cin = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset_state", {in_ready, out_valid, cout, ovf, sum}, {1'b1, 1'b0, 1'b0, 1'b0, W'(0)});

        issue(16'h0001, 16'h0002, 0, 0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 20);
        check("latency", 64'(n), 64'(NIBBLES));
        drain();
        issue(16'hFFFF, 16'h0000, 1, 0);
        issue(16'h7FFF, 16'h0001, 0, 0);
        issue(16'h8000, 16'h8000, 0, 0);
        drain();

        hold_ready = 0;
        @(posedge clk);
        issue(16'h0001, 16'h0002, 0, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall", {out_valid, in_ready, sum, cout, ovf}, {1'b1, 1'b0, 16'h0003, 1'b0, 1'b0});
            in_valid = 1; A = W'($urandom); B = W'($urandom);
        end
        @(negedge clk);
        in_valid = 0;
        hold_ready = 1;
        drain();
        check("idle_after_stall", {in_ready, out_valid}, 2'b10);

        issue(16'hAAAA, 16'h5555, 1, 0);
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        dummy = q.pop_back();
        @(negedge clk);
        check("abort_reset", {in_ready, out_valid, sum, cout, ovf}, {1'b1, 1'b0, W'(0), 1'b0, 1'b0});
        repeat (6) begin
            @(negedge clk);
            check("abort_no_output", {31'd0, out_valid}, 32'd0);
        end
        issue(16'h1234, 16'h4321, 0, 0);
        drain();
        check("after_abort", {sum, cout, ovf}, {16'h5555, 1'b0, 1'b0});

`ifdef SUMATOR_SERIAL_SUB_EN
        issue(16'h0005, 16'h0007, 1, 1);
        drain();
        check("sub", {sum, cout, ovf}, {16'hFFFE, 1'b0, 1'b0});
`endif

        rand_ready = 1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        rand_ready = 0;
        hold_ready = 1;
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
